// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with valid/ready flow control and a one-entry skid buffer.
// Optional: define IMM_GEN_PIPE_ILLEGAL_CNT_EN to add the saturating illegal_cnt output.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [ILEN-1:0] out_instr,
  output logic            out_illegal
`ifdef IMM_GEN_PIPE_ILLEGAL_CNT_EN
  ,
  output logic [15:0]     illegal_cnt
`endif
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  // Every supported opcode ends in 2'b11, so compressed encodings fall into the default arm.
  always_comb begin
    dec_imm32 = '0;
    dec_fmt   = FMT_ILL;
    dec_ill   = 1'b0;
    case (in_instr[6:0])
      7'b0110011, 7'b0111011: begin
        dec_fmt = FMT_R;
      end
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
      end
      default: begin
        dec_fmt = FMT_ILL;
        dec_ill = 1'b1;
      end
    endcase
  end

  generate
    if (XLEN > 32) begin : g_sext
      assign dec_imm = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
    end else begin : g_nosext
      assign dec_imm = dec_imm32;
    end
  endgenerate

  logic            m_valid_q, m_valid_d;
  logic [XLEN-1:0] m_imm_q,   m_imm_d;
  logic [2:0]      m_fmt_q,   m_fmt_d;
  logic [ILEN-1:0] m_instr_q, m_instr_d;
  logic            m_ill_q,   m_ill_d;
  logic            s_valid_q, s_valid_d;
  logic [XLEN-1:0] s_imm_q,   s_imm_d;
  logic [2:0]      s_fmt_q,   s_fmt_d;
  logic [ILEN-1:0] s_instr_q, s_instr_d;
  logic            s_ill_q,   s_ill_d;

  logic accept;
  logic xfer;

  assign accept = in_valid && !s_valid_q;
  assign xfer   = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_imm_d   = m_imm_q;
    m_fmt_d   = m_fmt_q;
    m_instr_d = m_instr_q;
    m_ill_d   = m_ill_q;
    s_valid_d = s_valid_q;
    s_imm_d   = s_imm_q;
    s_fmt_d   = s_fmt_q;
    s_instr_d = s_instr_q;
    s_ill_d   = s_ill_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (xfer && s_valid_q) begin
      // accept cannot be true here: in_ready was low because S was full.
      m_valid_d = 1'b1;
      m_imm_d   = s_imm_q;
      m_fmt_d   = s_fmt_q;
      m_instr_d = s_instr_q;
      m_ill_d   = s_ill_q;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || xfer) begin
      m_valid_d = accept;
      if (accept) begin
        m_imm_d   = dec_imm;
        m_fmt_d   = dec_fmt;
        m_instr_d = in_instr;
        m_ill_d   = dec_ill;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_imm_d   = dec_imm;
      s_fmt_d   = dec_fmt;
      s_instr_d = in_instr;
      s_ill_d   = dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_imm_q   <= '0;
      m_fmt_q   <= '0;
      m_instr_q <= '0;
      m_ill_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_imm_q   <= '0;
      s_fmt_q   <= '0;
      s_instr_q <= '0;
      s_ill_q   <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_imm_q   <= m_imm_d;
      m_fmt_q   <= m_fmt_d;
      m_instr_q <= m_instr_d;
      m_ill_q   <= m_ill_d;
      s_valid_q <= s_valid_d;
      s_imm_q   <= s_imm_d;
      s_fmt_q   <= s_fmt_d;
      s_instr_q <= s_instr_d;
      s_ill_q   <= s_ill_d;
    end
  end

  assign in_ready    = !s_valid_q;
  assign out_valid   = m_valid_q;
  assign out_imm     = m_imm_q;
  assign out_fmt     = m_fmt_q;
  assign out_instr   = m_instr_q;
  assign out_illegal = m_ill_q;

`ifdef IMM_GEN_PIPE_ILLEGAL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Survives flush on purpose; only reset clears the count.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && m_ill_q && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances fed identically)
// against a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_instr;
  logic [2:0]  out_fmt;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_instr64;
  logic [2:0]  out_fmt64;
`ifdef IMM_GEN_PIPE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt, illegal_cnt64;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_instr(out_instr), .out_illegal(out_illegal)
`ifdef IMM_GEN_PIPE_ILLEGAL_CNT_EN
    , .illegal_cnt(illegal_cnt)
`endif
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_instr(out_instr64), .out_illegal(out_illegal64)
`ifdef IMM_GEN_PIPE_ILLEGAL_CNT_EN
    , .illegal_cnt(illegal_cnt64)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] q[$];
  int cnt_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference decode, computed from the instruction-set field layouts.
  function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
    case (ins[6:0])
      7'h33, 7'h3B:                             return 3'd0;
      7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h0F: return 3'd1;
      7'h23:                                    return 3'd2;
      7'h63:                                    return 3'd3;
      7'h37, 7'h17:                             return 3'd4;
      7'h6F:                                    return 3'd5;
      default:                                  return 3'd7;
    endcase
  endfunction

  function automatic longint ref_imm(input logic [31:0] ins);
    case (ref_fmt(ins))
      3'd1: return longint'($signed(ins[31:20]));
      3'd2: return longint'($signed({ins[31:25], ins[11:7]}));
      3'd3: return longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'd4: return longint'($signed(ins[31:12])) * 4096;
      3'd5: return longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [16] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h0F,
                             7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B, 7'h00};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 15)];
    return r;
  endfunction

  task automatic check_outputs();
    logic [63:0] e;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid64", out_valid64, q.size() > 0);
    if (q.size() > 0) begin
      e = ref_imm(q[0]);
      chk("out_imm", out_imm, e[31:0]);
      chk("out_imm64", out_imm64, e);
      chk("out_fmt", out_fmt, ref_fmt(q[0]));
      chk("out_instr", out_instr, q[0]);
      chk("out_illegal", out_illegal, ref_fmt(q[0]) == 3'd7);
    end
`ifdef IMM_GEN_PIPE_ILLEGAL_CNT_EN
    chk("illegal_cnt", illegal_cnt, cnt_m);
`endif
  endtask

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic ordy,
                     input logic fl, input logic rs);
    logic acc, xf;
    in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl; reset = rs;
    @(negedge clk);
    check_outputs();
    acc = iv && (q.size() < 2);
    xf  = ordy && (q.size() > 0);
    @(posedge clk);
    if (rs) begin
      q.delete();
      cnt_m = 0;
    end else begin
      if (xf && ref_fmt(q[0]) == 3'd7 && cnt_m < 65535) cnt_m++;
      if (fl) q.delete();
      else begin
        if (xf) void'(q.pop_front());
        if (acc) q.push_back(ins);
      end
    end
    #1;
  endtask

  logic [31:0] stream_in  [5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
  logic [31:0] stream_imm [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
  logic [2:0]  stream_fmt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_fmt", out_fmt, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_illegal", out_illegal, 0);

    // back-to-back stream, each result visible one cycle after acceptance
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, stream_in[i], 1'b1, 1'b0, 1'b0);
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_imm", out_imm, stream_imm[i]);
      chk("stream_fmt", out_fmt, stream_fmt[i]);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // backpressure
    cyc(1'b1, 32'h00100093, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_after1", in_ready, 1'b1);
    cyc(1'b1, 32'h00200113, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_after2", in_ready, 1'b0);
    cyc(1'b1, 32'h00300193, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_held", in_ready, 1'b0);
    chk("bp_head_stable", out_instr, 32'h00100093);
    cyc(1'b1, 32'h00300193, 1'b1, 1'b0, 1'b0);
    chk("bp_ready_back", in_ready, 1'b1);
    repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // XLEN=64 upper-bit sign copy for lui
    cyc(1'b1, 32'h800002B7, 1'b1, 1'b0, 1'b0);
    chk("lui64_imm", out_imm64, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", out_fmt64, 3'd4);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // flush with M and S full and a concurrent input
    cyc(1'b1, 32'h00500293, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00600313, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00700393, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // illegal opcodes, counted from a clean reset
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b0);
      chk("ill_fmt", out_fmt, 3'd7);
      chk("ill_flag", out_illegal, 1'b1);
      chk("ill_imm", out_imm, 0);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
`ifdef IMM_GEN_PIPE_ILLEGAL_CNT_EN
    chk("ill_cnt3", illegal_cnt, 16'd3);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end

    // reset mid-backpressure
    cyc(1'b1, 32'h0000007F, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hFFF00093, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000013, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_imm", out_imm, 0);
    chk("mid_rst_fmt", out_fmt, 0);
    chk("mid_rst_instr", out_instr, 0);
    chk("mid_rst_illegal", out_illegal, 0);
`ifdef IMM_GEN_PIPE_ILLEGAL_CNT_EN
    chk("mid_rst_cnt", illegal_cnt, 16'd0);
`endif
    repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
